// File: rtl/vx_tensor_gpr_arb_pkg.sv
// Shared constants and helpers for the tensor GPR read-port arbiter.
// Widths that depend on module parameters are derived inside the modules.
package vx_tensor_gpr_arb_pkg;

  localparam int PERF_CTR_BITS = 16;

  // Clamp a width to at least one bit so zero-width fields stay legal.
  function automatic int up(input int x);
    return (x < 1) ? 1 : x;
  endfunction

endpackage

// File: rtl/vx_tensor_gpr_tag_fifo.sv
// In-order tag queue: registered occupancy, combinational head, 1-cycle push-to-visible.
// Push and pop may occur together, including when full; a pop on empty is ignored.
module vx_tensor_gpr_tag_fifo #(
  parameter int DATAW = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATAW-1:0]           push_dat,
  input  logic                       pop,
  output logic [DATAW-1:0]           pop_dat,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATAW-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vx_tensor_gpr_arb.sv
// Round-robin share of one GPR read port among operand collectors; responses routed back by tag.
// 0-cycle request and response paths; stalls when GPR not ready or tag FIFO full without a pop.
// Optional perf counters enabled by VX_TENSOR_GPR_ARB_PERF_EN.
module vx_tensor_gpr_arb
  import vx_tensor_gpr_arb_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int MAX_PENDING = 4,
  parameter int OPD_W       = 2,
  parameter int REG_W       = 5,
  parameter int WIS_W       = 4,
  parameter int SID_W       = 1,
  parameter int RSP_DATAW   = 128
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS*OPD_W-1:0]     req_opd_id,
  input  logic [NUM_REQS*WIS_W-1:0]     req_wis,
  input  logic [NUM_REQS*SID_W-1:0]     req_sid,
  input  logic [NUM_REQS*REG_W-1:0]     req_reg_id,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic [NUM_REQS-1:0]           rsp_valid,
  output logic [OPD_W-1:0]              rsp_opd_id,
  output logic [RSP_DATAW-1:0]          rsp_data,
  output logic                          gpr_req_valid,
  output logic [WIS_W-1:0]              gpr_req_wis,
  output logic [SID_W-1:0]              gpr_req_sid,
  output logic [REG_W-1:0]              gpr_req_reg_id,
  input  logic                          gpr_req_ready,
  input  logic                          gpr_rsp_valid,
  input  logic [RSP_DATAW-1:0]          gpr_rsp_data,
  output logic [$clog2(MAX_PENDING):0]  pending_count
`ifdef VX_TENSOR_GPR_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]      perf_stall_cycles,
  output logic [PERF_CTR_BITS-1:0]      perf_fifo_full_cycles
`endif
);
  localparam int IDX_W = up($clog2(NUM_REQS));
  localparam int TAG_W = IDX_W + OPD_W;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [OPD_W-1:0] opd_id;
  } tag_t;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  int               cand;
  logic             any_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             can_issue;
  logic             req_fire;
  logic             rsp_fire;
  tag_t             push_tag;
  tag_t             head_tag;

  assign any_req = |req_valid;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_idx = rr_ptr;
    cand      = 0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQS) cand = cand - NUM_REQS;
      if (req_valid[cand]) grant_idx = IDX_W'(cand);
    end
  end

  // A pop in the same cycle frees the slot the new push needs.
  assign can_issue     = ~fifo_full | gpr_rsp_valid;
  assign gpr_req_valid = any_req & can_issue;
  assign req_fire      = gpr_req_valid & gpr_req_ready;
  assign req_ready     = (any_req & gpr_req_ready & can_issue)
                         ? (NUM_REQS'(1) << grant_idx) : '0;

  assign gpr_req_wis    = req_wis[grant_idx*WIS_W +: WIS_W];
  assign gpr_req_sid    = req_sid[grant_idx*SID_W +: SID_W];
  assign gpr_req_reg_id = req_reg_id[grant_idx*REG_W +: REG_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (req_fire) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign push_tag.idx    = grant_idx;
  assign push_tag.opd_id = req_opd_id[grant_idx*OPD_W +: OPD_W];

  vx_tensor_gpr_tag_fifo #(
    .DATAW (TAG_W),
    .DEPTH (MAX_PENDING)
  ) tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (req_fire),
    .push_dat (push_tag),
    .pop      (gpr_rsp_valid),
    .pop_dat  (head_tag),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (pending_count)
  );

  // A response with nothing outstanding is dropped rather than misrouted.
  assign rsp_fire   = gpr_rsp_valid & ~fifo_empty;
  assign rsp_valid  = rsp_fire ? (NUM_REQS'(1) << head_tag.idx) : '0;
  assign rsp_opd_id = head_tag.opd_id;
  assign rsp_data   = gpr_rsp_data;

  a_rsp_without_req: assert property (@(posedge clk) disable iff (reset)
    !(gpr_rsp_valid && fifo_empty));

`ifdef VX_TENSOR_GPR_ARB_PERF_EN
  logic stall;
  logic full_stall;

  assign stall      = any_req & ~req_fire;
  assign full_stall = stall & fifo_full & ~rsp_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles     <= '0;
      perf_fifo_full_cycles <= '0;
    end else begin
      if (stall && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (full_stall && perf_fifo_full_cycles != '1)
        perf_fifo_full_cycles <= perf_fifo_full_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_tensor_gpr_arb.sv
// Bench for vx_tensor_gpr_arb: directed scenarios plus randomized traffic against a queue model.
module tb_vx_tensor_gpr_arb;
  import vx_tensor_gpr_arb_pkg::*;

  localparam int N   = 4;
  localparam int MP  = 4;
  localparam int DW  = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*2-1:0] req_opd_id;
  logic [N*4-1:0] req_wis;
  logic [N*1-1:0] req_sid;
  logic [N*5-1:0] req_reg_id;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [1:0]    rsp_opd_id;
  logic [DW-1:0] rsp_data;
  logic          gpr_req_valid;
  logic [3:0]    gpr_req_wis;
  logic [0:0]    gpr_req_sid;
  logic [4:0]    gpr_req_reg_id;
  logic          gpr_req_ready;
  logic          gpr_rsp_valid;
  logic [DW-1:0] gpr_rsp_data;
  logic [2:0]    pending_count;
`ifdef VX_TENSOR_GPR_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_stall_cycles;
  logic [PERF_CTR_BITS-1:0] perf_fifo_full_cycles;
  int exp_stall;
  int exp_full;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: outstanding tags in issue order, and where the next search starts.
  int q_idx[$];
  int q_opd[$];
  int next_start;

  always #5 clk = ~clk;

  vx_tensor_gpr_arb dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_opd_id     (req_opd_id),
    .req_wis        (req_wis),
    .req_sid        (req_sid),
    .req_reg_id     (req_reg_id),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_opd_id     (rsp_opd_id),
    .rsp_data       (rsp_data),
    .gpr_req_valid  (gpr_req_valid),
    .gpr_req_wis    (gpr_req_wis),
    .gpr_req_sid    (gpr_req_sid),
    .gpr_req_reg_id (gpr_req_reg_id),
    .gpr_req_ready  (gpr_req_ready),
    .gpr_rsp_valid  (gpr_rsp_valid),
    .gpr_rsp_data   (gpr_rsp_data),
    .pending_count  (pending_count)
`ifdef VX_TENSOR_GPR_ARB_PERF_EN
    ,
    .perf_stall_cycles     (perf_stall_cycles),
    .perf_fifo_full_cycles (perf_fifo_full_cycles)
`endif
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int opd, input int wis, input int sid, input int rg);
    req_opd_id[i*2 +: 2] = 2'(opd);
    req_wis[i*4 +: 4]    = 4'(wis);
    req_sid[i]           = 1'(sid);
    req_reg_id[i*5 +: 5] = 5'(rg);
  endtask

  // Per-cycle compare against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    int g;
    bit any, can, exp_gv, fire;
    if (reset) begin
      q_idx.delete();
      q_opd.delete();
      next_start = 0;
`ifdef VX_TENSOR_GPR_ARB_PERF_EN
      exp_stall = 0;
      exp_full  = 0;
`endif
    end else begin
      any = (req_valid != '0);
      g = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (req_valid[(next_start + k) % N]) g = (next_start + k) % N;
      end
      can    = (q_idx.size() < MP) || gpr_rsp_valid;
      exp_gv = any && can;
      fire   = exp_gv && gpr_req_ready;
      chk("m_gpr_req_valid", gpr_req_valid, exp_gv);
      if (exp_gv) begin
        chk("m_gpr_req_reg_id", gpr_req_reg_id, req_reg_id[g*5 +: 5]);
        chk("m_gpr_req_wis", gpr_req_wis, req_wis[g*4 +: 4]);
        chk("m_gpr_req_sid", gpr_req_sid, req_sid[g]);
      end
      chk("m_req_ready", req_ready, fire ? (1 << g) : 0);
      chk("m_pending_count", pending_count, q_idx.size());
      if (gpr_rsp_valid && q_idx.size() > 0) begin
        chk("m_rsp_valid", rsp_valid, 1 << q_idx[0]);
        chk("m_rsp_opd_id", rsp_opd_id, q_opd[0]);
        chk("m_rsp_data", rsp_data, gpr_rsp_data);
      end else begin
        chk("m_rsp_idle", rsp_valid, 0);
      end
`ifdef VX_TENSOR_GPR_ARB_PERF_EN
      chk("m_perf_stall", perf_stall_cycles, exp_stall);
      chk("m_perf_full", perf_fifo_full_cycles, exp_full);
      if (any && !fire) begin
        if (exp_stall < (1 << PERF_CTR_BITS) - 1) exp_stall++;
        if (q_idx.size() == MP && !gpr_rsp_valid && exp_full < (1 << PERF_CTR_BITS) - 1)
          exp_full++;
      end
`endif
      if (gpr_rsp_valid && q_idx.size() > 0) begin
        void'(q_idx.pop_front());
        void'(q_opd.pop_front());
      end
      if (fire) begin
        q_idx.push_back(g);
        q_opd.push_back(int'(req_opd_id[g*2 +: 2]));
        next_start = (g + 1) % N;
      end
    end
  end

  initial begin
    logic [DW-1:0] pat;
    int base_stall, base_full;
    reset = 1'b1;
    req_valid = '0; req_opd_id = '0; req_wis = '0; req_sid = '0; req_reg_id = '0;
    gpr_req_ready = 1'b0; gpr_rsp_valid = 1'b0; gpr_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    sample();
    chk("reset_pending", pending_count, 0);
    chk("reset_gpr_req_valid", gpr_req_valid, 0);
    chk("reset_rsp_valid", rsp_valid, 0);

    // Single request from collector 1, answered three cycles later.
    step();
    set_req(1, 2, 3, 1, 7);
    req_valid = 4'b0010; gpr_req_ready = 1'b1;
    sample();
    chk("single_gpr_req_valid", gpr_req_valid, 1);
    chk("single_reg_id", gpr_req_reg_id, 7);
    chk("single_req_ready", req_ready, 4'b0010);
    step(); req_valid = '0;
    step();
    step();
    pat = {16{8'hA5}};
    gpr_rsp_valid = 1'b1; gpr_rsp_data = pat;
    sample();
    chk("single_rsp_valid", rsp_valid, 4'b0010);
    chk("single_rsp_opd", rsp_opd_id, 2);
    chk("single_rsp_data", rsp_data, pat);

    // GPR stalled with collectors 2 and 3 waiting: grant must hold on 2.
    step();
    gpr_rsp_valid = 1'b0;
    set_req(2, 1, 5, 0, 9);
    set_req(3, 3, 6, 1, 11);
    req_valid = 4'b1100; gpr_req_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("stall_reg_id", gpr_req_reg_id, 9);
      chk("stall_req_ready", req_ready, 0);
      step();
    end
    gpr_req_ready = 1'b1;
    sample();
    chk("release_first", req_ready, 4'b0100);
    step();
    sample();
    chk("release_second", req_ready, 4'b1000);
    step();
    req_valid = '0; gpr_rsp_valid = 1'b1; gpr_rsp_data = {4{32'h1234_5678}};
    sample();
    chk("drain_rsp0", rsp_valid, 4'b0100);
    chk("drain_opd0", rsp_opd_id, 1);
    step();
    sample();
    chk("drain_rsp1", rsp_valid, 4'b1000);
    chk("drain_opd1", rsp_opd_id, 3);

    // Fill the tag FIFO from collector 0 with no responses.
    step();
    gpr_rsp_valid = 1'b0;
    set_req(0, 0, 1, 0, 3);
    req_valid = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      sample();
      chk("fill_req_ready", req_ready, 4'b0001);
      step();
    end
    sample();
    chk("full_gpr_req_valid", gpr_req_valid, 0);
    chk("full_req_ready", req_ready, 0);
    chk("full_pending", pending_count, 4);
`ifdef VX_TENSOR_GPR_ARB_PERF_EN
    base_stall = int'(perf_stall_cycles);
    base_full  = int'(perf_fifo_full_cycles);
`else
    base_stall = 0;
    base_full  = 0;
`endif
    repeat (5) begin
      step();
      sample();
      chk("full_hold_req_ready", req_ready, 0);
    end
    step();
    gpr_rsp_valid = 1'b1; gpr_rsp_data = {4{32'hCAFE_F00D}};
    sample();
`ifdef VX_TENSOR_GPR_ARB_PERF_EN
    chk("perf_stall_delta", int'(perf_stall_cycles) - base_stall, 6);
    chk("perf_full_delta", int'(perf_fifo_full_cycles) - base_full, 6);
`else
    chk("perf_base_zero", base_stall + base_full, 0);
`endif
    chk("swap_req_ready", req_ready, 4'b0001);
    chk("swap_rsp_valid", rsp_valid, 4'b0001);
    step();
    gpr_rsp_valid = 1'b0; req_valid = '0;
    sample();
    chk("swap_pending", pending_count, 4);
    step();
    gpr_rsp_valid = 1'b1;
    sample();
    step();
    gpr_rsp_valid = 1'b0;
    sample();
    chk("pre_reset_pending", pending_count, 3);

    // Reset with three outstanding, then full-rate round robin from pointer 0.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sample();
    chk("post_reset_pending", pending_count, 0);
    chk("post_reset_rsp_valid", rsp_valid, 0);
    step();
    for (int i = 0; i < N; i++) set_req(i, i, i + 8, i % 2, 20 + i);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      sample();
      chk("rr_grant", req_ready, 1 << (c % 4));
      if (c > 0) chk("rr_route", rsp_valid, 1 << ((c - 1) % 4));
      step();
      gpr_rsp_valid = 1'b1; gpr_rsp_data = {$urandom, $urandom, $urandom, $urandom};
    end
    req_valid = '0;
    sample();
    step();
    gpr_rsp_valid = 1'b0;

    // Randomized traffic, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      step();
      reset = (($urandom % 400) == 0);
      req_valid = N'($urandom);
      req_opd_id = 8'($urandom); req_wis = 16'($urandom);
      req_sid = 4'($urandom); req_reg_id = 20'($urandom);
      gpr_req_ready = (($urandom % 4) != 0);
      gpr_rsp_valid = (q_idx.size() > 0) && (($urandom % 2) == 1);
      gpr_rsp_data = {$urandom, $urandom, $urandom, $urandom};
    end
    step();
    reset = 1'b0; req_valid = '0; gpr_rsp_valid = 1'b0;
    sample();
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
